// File: rtl/demux_serial_ctrl.sv
// ----------------------------------------------------------------------------
// demux_serial_ctrl: feeds a serial bit stream into a 1-to-4 demux, reads the
// q outputs back into a word and flags inconsistent q patterns.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux_serial_ctrl #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       a0,
  output logic       a1,
  output logic       d,
  input  logic       q0,
  input  logic       q1,
  input  logic       q2,
  input  logic       q3,
  output logic       out_valid,
  output logic [3:0] out_word,
  input  logic       out_ready,
  output logic       abort,
  output logic       err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [1:0] c_first_slot = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0] c_last_slot  = MSB_FIRST ? 2'd0 : 2'd3;
  localparam logic [3:0] c_timeout    = TIMEOUT[3:0];

  state_e     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic [1:0] addr_q, addr_d;
  logic       d_q, d_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_word_q, out_word_d;
  logic       abort_q, abort_d;
  logic       err_q, err_d;
  logic [1:0] slot_q, slot_d;
  logic       cap_pending_q, cap_pending_d;
  logic [1:0] cap_slot_q, cap_slot_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;

  logic [3:0] w_q_bus;
  logic [3:0] w_q_expect;
  logic [3:0] w_idle_inc;
  logic [1:0] w_slot_next;
  logic       w_xfer;

  assign w_q_bus     = {q3, q2, q1, q0};
  assign w_xfer      = in_valid & in_ready_q;
  // The demux drives only the addressed output, and only while d is high.
  assign w_q_expect  = (4'b0001 << cap_slot_q) & {4{d_q}};
  assign w_idle_inc  = idle_cnt_q + 4'd1;
  assign w_slot_next = MSB_FIRST ? (slot_q - 2'd1) : (slot_q + 2'd1);

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    addr_d        = addr_q;
    d_d           = 1'b0;
    out_valid_d   = out_valid_q;
    out_word_d    = out_word_q;
    abort_d       = 1'b0;
    err_d         = err_q;
    slot_d        = slot_q;
    cap_pending_d = cap_pending_q;
    cap_slot_d    = cap_slot_q;
    idle_cnt_d    = idle_cnt_q;

    if (cap_pending_q) begin
      out_word_d[cap_slot_q] = w_q_bus[cap_slot_q];
      if (w_q_bus != w_q_expect) begin
        err_d = 1'b1;
      end
      cap_pending_d = 1'b0;
    end

    unique case (state_q)
      COLLECT: begin
        in_ready_d = 1'b1;
        if (w_xfer) begin
          addr_d        = slot_q;
          d_d           = in_data;
          cap_pending_d = 1'b1;
          cap_slot_d    = slot_q;
          slot_d        = w_slot_next;
          idle_cnt_d    = 4'd0;
          if (slot_q == c_last_slot) begin
            in_ready_d = 1'b0;
            state_d    = DRAIN;
          end
        end else if ((TIMEOUT != 0) && (slot_q != c_first_slot)) begin
          // A timeout discards the partial word even if a capture lands now.
          if (w_idle_inc == c_timeout) begin
            out_word_d = 4'd0;
            slot_d     = c_first_slot;
            idle_cnt_d = 4'd0;
            abort_d    = 1'b1;
          end else begin
            idle_cnt_d = w_idle_inc;
          end
        end
      end
      DRAIN: begin
        if (cap_pending_q) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_word_d  = 4'd0;
          slot_d      = c_first_slot;
          in_ready_d  = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      in_ready_q    <= 1'b0;
      addr_q        <= c_first_slot;
      d_q           <= 1'b0;
      out_valid_q   <= 1'b0;
      out_word_q    <= 4'd0;
      abort_q       <= 1'b0;
      err_q         <= 1'b0;
      slot_q        <= c_first_slot;
      cap_pending_q <= 1'b0;
      cap_slot_q    <= c_first_slot;
      idle_cnt_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      addr_q        <= addr_d;
      d_q           <= d_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      abort_q       <= abort_d;
      err_q         <= err_d;
      slot_q        <= slot_d;
      cap_pending_q <= cap_pending_d;
      cap_slot_q    <= cap_slot_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign a0        = addr_q[0];
  assign a1        = addr_q[1];
  assign d         = d_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign abort     = abort_q;
  assign err       = err_q;

endmodule

`default_nettype wire
